// File: rtl/jpeg_rle_pkg.sv
// Shared types and constants for the JPEG AC run-length/category encoder.
package jpeg_rle_pkg;

    localparam int unsigned RUN_W  = 4;
    localparam int unsigned SIZE_W = 4;

    localparam logic [RUN_W-1:0] ZRL_RUN = 4'd15;

    typedef enum logic [0:0] {
        S_RUN = 1'b0,
        S_ZRL = 1'b1
    } rle_state_t;

    // Amplitude lives beside the struct because its width follows COEF_W.
    typedef struct packed {
        logic [RUN_W-1:0]  run;
        logic [SIZE_W-1:0] size;
        logic              is_dc;
        logic              zrl;
        logic              eob;
        logic              block_end;
    } rle_sym_t;

endpackage

// File: rtl/jpeg_coef_sizer.sv
// Combinational coefficient -> (magnitude category, JPEG amplitude bits, zero flag).
module jpeg_coef_sizer
    import jpeg_rle_pkg::*;
#(
    parameter int unsigned COEF_W = 12
) (
    input  logic [COEF_W-1:0] coef,
    output logic [SIZE_W-1:0] size,
    output logic [COEF_W-1:0] amp,
    output logic              is_zero
);

    localparam logic [COEF_W-1:0] MIN_VAL   = {1'b1, {(COEF_W-1){1'b0}}};
    localparam logic [COEF_W-1:0] CLAMP_VAL = {1'b1, {(COEF_W-2){1'b0}}, 1'b1};

    logic [COEF_W-1:0] coef_c;
    logic [COEF_W-1:0] mag;
    logic [COEF_W-1:0] mask;

    always_comb begin
        // The most negative code has no positive magnitude; treat it as one step less.
        coef_c = (coef == MIN_VAL) ? CLAMP_VAL : coef;
        mag    = coef_c[COEF_W-1] ? (~coef_c + COEF_W'(1)) : coef_c;

        size = '0;
        for (int i = 0; i < COEF_W; i++) begin
            if (mag[i]) begin
                size = SIZE_W'(i + 1);
            end
        end

        mask = '0;
        for (int i = 0; i < COEF_W; i++) begin
            if (i < int'(size)) begin
                mask[i] = 1'b1;
            end
        end

        amp     = coef_c[COEF_W-1] ? ((coef_c - COEF_W'(1)) & mask) : coef_c;
        is_zero = (coef == '0);
    end

endmodule

// File: rtl/jpeg_ac_rle_encoder.sv
// Turns a zigzag-ordered block of quantised coefficients into DC, AC, ZRL and EOB symbols.
module jpeg_ac_rle_encoder
    import jpeg_rle_pkg::*;
#(
    parameter int unsigned COEF_W    = 12,
    parameter int unsigned BLOCK_LEN = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [COEF_W-1:0] in_coef,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [RUN_W-1:0]  out_run,
    output logic [SIZE_W-1:0] out_size,
    output logic [COEF_W-1:0] out_amp,
    output logic              out_is_dc,
    output logic              out_zrl,
    output logic              out_eob,
    output logic              out_block_end
);

    localparam int unsigned IDX_W  = $clog2(BLOCK_LEN);
    localparam int unsigned ZRUN_W = IDX_W;

    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(BLOCK_LEN - 1);
    localparam logic [ZRUN_W-1:0] ZRL_LEN  = ZRUN_W'(16);

    rle_state_t         state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [ZRUN_W-1:0]  zrun_q, zrun_d;
    logic               valid_q, valid_d;
    rle_sym_t           sym_q, sym_d;
    logic [COEF_W-1:0]  amp_q, amp_d;
    logic [SIZE_W-1:0]  hold_size_q, hold_size_d;
    logic [COEF_W-1:0]  hold_amp_q, hold_amp_d;
    logic               hold_last_q, hold_last_d;

    logic [SIZE_W-1:0]  c_size;
    logic [COEF_W-1:0]  c_amp;
    logic               c_zero;
    logic               accept;
    logic               is_last;
    logic [ZRUN_W-1:0]  zrun_sub;

    jpeg_coef_sizer #(
        .COEF_W (COEF_W)
    ) u_sizer (
        .coef    (in_coef),
        .size    (c_size),
        .amp     (c_amp),
        .is_zero (c_zero)
    );

    assign in_ready = (state_q == S_RUN) & (~valid_q | out_ready) & ~rst;
    assign accept   = in_valid & in_ready;
    assign is_last  = (idx_q == LAST_IDX);
    assign zrun_sub = zrun_q - ZRL_LEN;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        zrun_d      = zrun_q;
        valid_d     = valid_q;
        sym_d       = sym_q;
        amp_d       = amp_q;
        hold_size_d = hold_size_q;
        hold_amp_d  = hold_amp_q;
        hold_last_d = hold_last_q;

        if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end

        case (state_q)
            S_RUN: begin
                if (accept) begin
                    idx_d = is_last ? '0 : idx_q + IDX_W'(1);
                    if (idx_q == '0) begin
                        valid_d     = 1'b1;
                        sym_d       = '0;
                        sym_d.size  = c_size;
                        sym_d.is_dc = 1'b1;
                        amp_d       = c_amp;
                        zrun_d      = '0;
                    end else if (c_zero) begin
                        if (is_last) begin
                            // Trailing zeros collapse into EOB; the pending run is dropped.
                            valid_d         = 1'b1;
                            sym_d           = '0;
                            sym_d.eob       = 1'b1;
                            sym_d.block_end = 1'b1;
                            amp_d           = '0;
                            zrun_d          = '0;
                        end else begin
                            zrun_d = zrun_q + ZRUN_W'(1);
                        end
                    end else if (zrun_q < ZRL_LEN) begin
                        valid_d         = 1'b1;
                        sym_d           = '0;
                        sym_d.run       = zrun_q[RUN_W-1:0];
                        sym_d.size      = c_size;
                        sym_d.block_end = is_last;
                        amp_d           = c_amp;
                        zrun_d          = '0;
                    end else begin
                        // Park the AC symbol and drain ZRLs ahead of it.
                        hold_size_d = c_size;
                        hold_amp_d  = c_amp;
                        hold_last_d = is_last;
                        valid_d     = 1'b1;
                        sym_d       = '0;
                        sym_d.run   = ZRL_RUN;
                        sym_d.zrl   = 1'b1;
                        amp_d       = '0;
                        state_d     = S_ZRL;
                    end
                end
            end
            S_ZRL: begin
                if (valid_q && out_ready) begin
                    valid_d = 1'b1;
                    if (zrun_sub < ZRL_LEN) begin
                        sym_d           = '0;
                        sym_d.run       = zrun_sub[RUN_W-1:0];
                        sym_d.size      = hold_size_q;
                        sym_d.block_end = hold_last_q;
                        amp_d           = hold_amp_q;
                        zrun_d          = '0;
                        state_d         = S_RUN;
                    end else begin
                        zrun_d = zrun_sub;
                    end
                end
            end
            default: state_d = S_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_RUN;
            idx_q       <= '0;
            zrun_q      <= '0;
            valid_q     <= 1'b0;
            sym_q       <= '0;
            amp_q       <= '0;
            hold_size_q <= '0;
            hold_amp_q  <= '0;
            hold_last_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            zrun_q      <= zrun_d;
            valid_q     <= valid_d;
            sym_q       <= sym_d;
            amp_q       <= amp_d;
            hold_size_q <= hold_size_d;
            hold_amp_q  <= hold_amp_d;
            hold_last_q <= hold_last_d;
        end
    end

    assign out_valid     = valid_q;
    assign out_run       = sym_q.run;
    assign out_size      = sym_q.size;
    assign out_amp       = amp_q;
    assign out_is_dc     = sym_q.is_dc;
    assign out_zrl       = sym_q.zrl;
    assign out_eob       = sym_q.eob;
    assign out_block_end = sym_q.block_end;

endmodule
